roce_stack_cmd_generator: RTL and testbench
===========================================

Name: roce_stack_cmd_generator

Overview:
- Parametrised successor to the single-context RoCE request handler. Turns RDMA read/write requests into AXI DataMover S2MM/MM2S commands.
- Per-QP continuation contexts allow multi-packet messages on different QPs to interleave.
- Commands longer than the DataMover limit are split into several chunks, and each command carries a rolling tag.
- Sits between the RoCE stack request interface, the vaddr→paddr translation table and the DataMover command port.

Parameters:
ADDR_WIDTH, 64, virtual/physical address width
LEN_WIDTH, 28, request length width (bytes)
QPN_WIDTH, 16, queue-pair number width
BTT_WIDTH, 23, DataMover bytes-to-transfer field width
MAX_CMD_LEN, 4096, max bytes per emitted command; 1 ≤ MAX_CMD_LEN ≤ 2^BTT_WIDTH−1
NUM_QP_SLOTS, 8, context slots (power of 2); slot index = qpn[log2(NUM_QP_SLOTS)−1:0]
CMD_WIDTH, 17+ADDR_WIDTH+BTT_WIDTH, derived; 104 at defaults

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
s_rdma_req_valid_i  in  1  request valid
s_rdma_req_ready_o  out  1  request accepted
s_rdma_req_vaddr_i  in  ADDR_WIDTH  vaddr; used only on the first packet of a message
s_rdma_req_len_i  in  LEN_WIDTH  packet length in bytes
s_rdma_req_qpn_i  in  QPN_WIDTH  queue pair
s_rdma_req_last_i  in  1  last packet of message
req_addr_valid_o / req_addr_ready_i  out/in  1  translation request handshake
req_addr_vaddr_o  out  ADDR_WIDTH  vaddr to translate
req_addr_qpn_o  out  QPN_WIDTH  qpn to translate
resp_addr_valid_i / resp_addr_ready_o  in/out  1  translation response handshake
resp_paddr_i  in  ADDR_WIDTH  physical base
resp_buflen_i  in  48  buffer length
resp_accessdesc_i  in  4  access descriptor
cmd_valid_o / cmd_ready_i  out/in  1  DataMover command handshake
cmd_data_o  out  CMD_WIDTH  {4'b0, tag[3:0], paddr, 1'b0 DRR, eof, 6'b0 DSA, 1'b1 INCR, btt}
err_o  out  1  one-cycle error pulse
err_code_o  out  2  01 = QP alias, 10 = bounds (feature only); held until the next error

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE.
  - All outputs 0, including s_rdma_req_ready_o; ready is gated low while rst_i is high.
  - Tag = 0. Every slot has first=1, valid=0.
  - Reset mid-operation abandons the current command with no completion.
- Slot context: next_paddr[ADDR_WIDTH], first, qpn_tag[QPN_WIDTH], valid.
- IDLE: s_rdma_req_ready_o = 1. On valid&ready, capture vaddr, len, qpn and last, then look up the slot:
  - slot.first = 1: set slot.qpn_tag = qpn and go to LOOKUP.
  - slot.first = 0 and qpn_tag == qpn: working paddr = slot.next_paddr, go to EMIT.
  - slot.first = 0 and qpn_tag ≠ qpn: err_o pulses with code 01, the request is dropped, the slot is untouched, and the block stays in IDLE.
- LOOKUP: req_addr_valid_o = 1 with the captured vaddr and qpn. On req_addr_ready_i, go to WAIT_RESP. valid must not drop before ready.
- WAIT_RESP: resp_addr_ready_o = 1. On resp_addr_valid_i, working paddr = resp_paddr_i, then go to EMIT. resp_addr_ready_o is 0 in every other state.
- EMIT:
  - btt = min(remaining, MAX_CMD_LEN).
  - eof = last & (remaining ≤ MAX_CMD_LEN).
  - cmd_valid_o = 1, with cmd_data_o registered and stable until the handshake.
  - On cmd_ready_i: paddr += btt, remaining −= btt, tag += 1 (wraps 15→0).
  - If remaining becomes 0: slot.next_paddr = paddr, slot.first = last, go to IDLE. Otherwise stay in EMIT; next chunk valid the following cycle.
- Zero-length request: no command is emitted. The slot is updated (first = last, next_paddr unchanged), and the block returns to IDLE one cycle after LOOKUP/WAIT_RESP, or directly in the case of a continuation.
- Latency, request accept → cmd_valid_o:
  - 1 cycle for a continuation.
  - 2 + translation latency cycles for a first packet.
- Arithmetic:
  - Address sums wrap modulo 2^ADDR_WIDTH.
  - btt is zero-extended into BTT_WIDTH.
  - LEN_WIDTH > BTT_WIDTH is legal because of splitting.
- Only one request is in flight at a time. Back-pressure on cmd_ready_i stalls indefinitely with no loss.

Optional Feature:
- ROCE_REQ_BOUNDS_CHECK_EN defined:
  - On a first packet, the block records the buffer end = resp_paddr_i + resp_buflen_i in the slot.
  - Any packet with paddr + len > end is rejected. Rejection means err_o pulses with code 10, no command is emitted, slot.first is set to 1, and the block returns to IDLE.
  - resp_accessdesc_i == 0 is rejected the same way.
- ROCE_REQ_BOUNDS_CHECK_EN undefined: buflen and accessdesc are ignored, there is no end register, and code 10 never occurs.

Test Plan:
- First packet qpn=3, vaddr=0x1000, len=256, last=1; translation returns paddr=0x8000_0000 → one cmd: paddr=0x8000_0000, btt=256, eof=1, tag=0. Slot 3 first=1.
- qpn=5 message of three packets, 1024 B each, last on the third; paddr=0x2000 → a single translation; cmds at 0x2000, 0x2400, 0x2800; eof only on the third; tags 0,1,2.
- MAX_CMD_LEN=4096, len=10000, last=1 → btt 4096/4096/1808; paddrs base, +0x1000, +0x2000; eof only on the last; cmd_ready_i held low 5 cycles mid-way → cmd_data_o stable, nothing lost.
- Interleaving and alias, NUM_QP_SLOTS=8:
  - qpn=1 first (last=0), then qpn=2 first (last=0), then qpn=1 middle → continues from qpn 1's next_paddr with no lookup.
  - qpn=9 middle while slot 1 is open → err_o pulse, code 01, no cmd.
- Assert rst_i during EMIT with cmd_ready_i=0 → cmd_valid_o drops immediately, all slots first=1, tag=0. The next request triggers a lookup.
- With ROCE_REQ_BOUNDS_CHECK_EN, buflen=512 and a first packet of len=600 → err code 10, no cmd, slot first=1.

Source files
------------

// File: rtl/roce_stack_cmd_generator.sv
// RoCE request -> AXI DataMover command generator with per-QP continuation slots.
// Optional buffer bounds checking is enabled by defining ROCE_REQ_BOUNDS_CHECK_EN.
module roce_stack_cmd_generator #(
   parameter int ADDR_WIDTH   = 64,
   parameter int LEN_WIDTH    = 28,
   parameter int QPN_WIDTH    = 16,
   parameter int BTT_WIDTH    = 23,
   parameter int MAX_CMD_LEN  = 4096,
   parameter int NUM_QP_SLOTS = 8,
   parameter int CMD_WIDTH    = 17 + ADDR_WIDTH + BTT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_rdma_req_valid_i,
   output logic                  s_rdma_req_ready_o,
   input  logic [ADDR_WIDTH-1:0] s_rdma_req_vaddr_i,
   input  logic [LEN_WIDTH-1:0]  s_rdma_req_len_i,
   input  logic [QPN_WIDTH-1:0]  s_rdma_req_qpn_i,
   input  logic                  s_rdma_req_last_i,
   output logic                  req_addr_valid_o,
   input  logic                  req_addr_ready_i,
   output logic [ADDR_WIDTH-1:0] req_addr_vaddr_o,
   output logic [QPN_WIDTH-1:0]  req_addr_qpn_o,
   input  logic                  resp_addr_valid_i,
   output logic                  resp_addr_ready_o,
   input  logic [ADDR_WIDTH-1:0] resp_paddr_i,
   input  logic [47:0]           resp_buflen_i,
   input  logic [3:0]            resp_accessdesc_i,
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic [CMD_WIDTH-1:0]  cmd_data_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o
);

   localparam int SLOT_W = $clog2(NUM_QP_SLOTS);
   localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_CMD_LEN);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT_RESP, S_EMIT} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [QPN_WIDTH-1:0]  qpn_q, qpn_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [3:0]            tag_q, tag_d;
   logic                  err_q, err_d;
   logic [1:0]            err_code_q, err_code_d;

   logic [ADDR_WIDTH-1:0] slot_paddr_q [NUM_QP_SLOTS];
   logic [ADDR_WIDTH-1:0] slot_paddr_d [NUM_QP_SLOTS];
   logic [QPN_WIDTH-1:0]  slot_tag_q   [NUM_QP_SLOTS];
   logic [QPN_WIDTH-1:0]  slot_tag_d   [NUM_QP_SLOTS];
   logic [NUM_QP_SLOTS-1:0] slot_first_q, slot_first_d;
   logic [NUM_QP_SLOTS-1:0] slot_valid_q, slot_valid_d;
`ifdef ROCE_REQ_BOUNDS_CHECK_EN
   logic [ADDR_WIDTH-1:0] slot_end_q [NUM_QP_SLOTS];
   logic [ADDR_WIDTH-1:0] slot_end_d [NUM_QP_SLOTS];
   logic [ADDR_WIDTH-1:0] new_end;
`else
   logic unused_in;
   assign unused_in = ^{resp_buflen_i, resp_accessdesc_i};
`endif

   logic [SLOT_W-1:0]    in_idx, cur_idx;
   logic [LEN_WIDTH-1:0] chunk;
   logic [BTT_WIDTH-1:0] btt;
   logic                 eof;
   logic                 accept;

   assign in_idx  = s_rdma_req_qpn_i[SLOT_W-1:0];
   assign cur_idx = qpn_q[SLOT_W-1:0];
   assign chunk   = (rem_q > MAX_L) ? MAX_L : rem_q;
   assign btt     = BTT_WIDTH'(chunk);
   assign eof     = last_q & (rem_q <= MAX_L);

   assign s_rdma_req_ready_o = (state_q == S_IDLE) & ~rst_i;
   assign accept             = s_rdma_req_valid_i & s_rdma_req_ready_o;
   assign req_addr_vaddr_o   = vaddr_q;
   assign req_addr_qpn_o     = qpn_q;
   assign err_o              = err_q;
   assign err_code_o         = err_code_q;
   assign cmd_data_o = cmd_valid_o ?
      {4'b0, tag_q, paddr_q, 1'b0, eof, 6'b0, 1'b1, btt} : '0;

   // Next-state, slot updates and handshake outputs.
   always_comb begin
      state_d           = state_q;
      vaddr_d           = vaddr_q;
      rem_d             = rem_q;
      qpn_d             = qpn_q;
      last_d            = last_q;
      paddr_d           = paddr_q;
      tag_d             = tag_q;
      err_d             = 1'b0;
      err_code_d        = err_code_q;
      slot_paddr_d      = slot_paddr_q;
      slot_tag_d        = slot_tag_q;
      slot_first_d      = slot_first_q;
      slot_valid_d      = slot_valid_q;
`ifdef ROCE_REQ_BOUNDS_CHECK_EN
      slot_end_d        = slot_end_q;
      new_end           = resp_paddr_i + ADDR_WIDTH'(resp_buflen_i);
`endif
      req_addr_valid_o  = 1'b0;
      resp_addr_ready_o = 1'b0;
      cmd_valid_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               vaddr_d = s_rdma_req_vaddr_i;
               rem_d   = s_rdma_req_len_i;
               qpn_d   = s_rdma_req_qpn_i;
               last_d  = s_rdma_req_last_i;
               if (slot_first_q[in_idx]) begin
                  slot_tag_d[in_idx]   = s_rdma_req_qpn_i;
                  slot_valid_d[in_idx] = 1'b1;
                  state_d              = S_LOOKUP;
               end else if (slot_valid_q[in_idx] &&
                            slot_tag_q[in_idx] == s_rdma_req_qpn_i) begin
                  paddr_d = slot_paddr_q[in_idx];
`ifdef ROCE_REQ_BOUNDS_CHECK_EN
                  if (slot_paddr_q[in_idx] + ADDR_WIDTH'(s_rdma_req_len_i)
                      > slot_end_q[in_idx]) begin
                     err_d                = 1'b1;
                     err_code_d           = 2'b10;
                     slot_first_d[in_idx] = 1'b1;
                  end else
`endif
                  if (s_rdma_req_len_i == '0)
                     slot_first_d[in_idx] = s_rdma_req_last_i;
                  else
                     state_d = S_EMIT;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
               end
            end
         end
         S_LOOKUP: begin
            req_addr_valid_o = 1'b1;
            if (req_addr_ready_i) state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            resp_addr_ready_o = 1'b1;
            if (resp_addr_valid_i) begin
               paddr_d = resp_paddr_i;
               state_d = S_EMIT;
`ifdef ROCE_REQ_BOUNDS_CHECK_EN
               slot_end_d[cur_idx] = new_end;
               if (resp_accessdesc_i == 4'd0 ||
                   resp_paddr_i + ADDR_WIDTH'(rem_q) > new_end) begin
                  err_d                 = 1'b1;
                  err_code_d            = 2'b10;
                  slot_first_d[cur_idx] = 1'b1;
                  state_d               = S_IDLE;
               end
`endif
            end
         end
         S_EMIT: begin
            if (rem_q == '0) begin
               slot_paddr_d[cur_idx] = paddr_q;
               slot_first_d[cur_idx] = last_q;
               state_d               = S_IDLE;
            end else begin
               cmd_valid_o = 1'b1;
               if (cmd_ready_i) begin
                  paddr_d = paddr_q + ADDR_WIDTH'(chunk);
                  rem_d   = rem_q - chunk;
                  tag_d   = tag_q + 4'd1;
                  if (rem_q == chunk) begin
                     slot_paddr_d[cur_idx] = paddr_q + ADDR_WIDTH'(chunk);
                     slot_first_d[cur_idx] = last_q;
                     state_d               = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, working registers and slot contexts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         vaddr_q      <= '0;
         rem_q        <= '0;
         qpn_q        <= '0;
         last_q       <= 1'b0;
         paddr_q      <= '0;
         tag_q        <= '0;
         err_q        <= 1'b0;
         err_code_q   <= '0;
         slot_first_q <= '1;
         slot_valid_q <= '0;
         for (int i = 0; i < NUM_QP_SLOTS; i++) begin
            slot_paddr_q[i] <= '0;
            slot_tag_q[i]   <= '0;
`ifdef ROCE_REQ_BOUNDS_CHECK_EN
            slot_end_q[i]   <= '0;
`endif
         end
      end else begin
         state_q      <= state_d;
         vaddr_q      <= vaddr_d;
         rem_q        <= rem_d;
         qpn_q        <= qpn_d;
         last_q       <= last_d;
         paddr_q      <= paddr_d;
         tag_q        <= tag_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         slot_first_q <= slot_first_d;
         slot_valid_q <= slot_valid_d;
         slot_paddr_q <= slot_paddr_d;
         slot_tag_q   <= slot_tag_d;
`ifdef ROCE_REQ_BOUNDS_CHECK_EN
         slot_end_q   <= slot_end_d;
`endif
      end
   end

endmodule

// File: tb/tb_roce_stack_cmd_generator.sv
// Directed bench for roce_stack_cmd_generator at default parameters.
// Translation side always ready; paddr/buflen supplied from bench variables.
module tb_roce_stack_cmd_generator;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         s_rdma_req_valid_i = 1'b0;
   logic         s_rdma_req_ready_o;
   logic [63:0]  s_rdma_req_vaddr_i = '0;
   logic [27:0]  s_rdma_req_len_i = '0;
   logic [15:0]  s_rdma_req_qpn_i = '0;
   logic         s_rdma_req_last_i = 1'b0;
   logic         req_addr_valid_o;
   logic         req_addr_ready_i = 1'b1;
   logic [63:0]  req_addr_vaddr_o;
   logic [15:0]  req_addr_qpn_o;
   logic         resp_addr_valid_i = 1'b1;
   logic         resp_addr_ready_o;
   logic [63:0]  resp_paddr_i = '0;
   logic [47:0]  resp_buflen_i = 48'hFFFF_FFFF;
   logic [3:0]   resp_accessdesc_i = 4'h1;
   logic         cmd_valid_o;
   logic         cmd_ready_i = 1'b0;
   logic [103:0] cmd_data_o;
   logic         err_o;
   logic [1:0]   err_code_o;

   int checks = 0;
   int errors = 0;
   int lookups = 0;
   int base;
   int w;
   logic [63:0] lk_vaddr;
   logic [15:0] lk_qpn;

   roce_stack_cmd_generator dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_rdma_req_valid_i(s_rdma_req_valid_i),
      .s_rdma_req_ready_o(s_rdma_req_ready_o),
      .s_rdma_req_vaddr_i(s_rdma_req_vaddr_i),
      .s_rdma_req_len_i(s_rdma_req_len_i),
      .s_rdma_req_qpn_i(s_rdma_req_qpn_i),
      .s_rdma_req_last_i(s_rdma_req_last_i),
      .req_addr_valid_o(req_addr_valid_o),
      .req_addr_ready_i(req_addr_ready_i),
      .req_addr_vaddr_o(req_addr_vaddr_o),
      .req_addr_qpn_o(req_addr_qpn_o),
      .resp_addr_valid_i(resp_addr_valid_i),
      .resp_addr_ready_o(resp_addr_ready_o),
      .resp_paddr_i(resp_paddr_i),
      .resp_buflen_i(resp_buflen_i),
      .resp_accessdesc_i(resp_accessdesc_i),
      .cmd_valid_o(cmd_valid_o),
      .cmd_ready_i(cmd_ready_i),
      .cmd_data_o(cmd_data_o),
      .err_o(err_o),
      .err_code_o(err_code_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i)
      if (req_addr_valid_o && req_addr_ready_i) begin
         lookups  <= lookups + 1;
         lk_vaddr <= req_addr_vaddr_o;
         lk_qpn   <= req_addr_qpn_o;
      end

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [103:0] mk_cmd(input logic [3:0] tag,
      input logic [63:0] pa, input logic [22:0] btt, input logic eof);
      return {4'b0, tag, pa, 1'b0, eof, 6'b0, 1'b1, btt};
   endfunction

   task automatic do_reset();
      rst_i = 1'b1;
      s_rdma_req_valid_i = 1'b0;
      cmd_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", s_rdma_req_ready_o, 1'b0);
      check("rst_outs", {cmd_valid_o, err_o, req_addr_valid_o,
                         resp_addr_ready_o, cmd_data_o}, '0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_req(input logic [63:0] va, input logic [27:0] len,
                           input logic [15:0] qpn, input logic last);
      int n = 0;
      s_rdma_req_vaddr_i = va;
      s_rdma_req_len_i   = len;
      s_rdma_req_qpn_i   = qpn;
      s_rdma_req_last_i  = last;
      s_rdma_req_valid_i = 1'b1;
      while (!s_rdma_req_ready_o && n < 50) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (n == 50) check("req_accept_timeout", 1'b0, 1'b1);
      @(posedge clk_i);
      #1;
      s_rdma_req_valid_i = 1'b0;
   endtask

   task automatic expect_cmd(input string nm, input logic [3:0] tag,
      input logic [63:0] pa, input logic [22:0] btt, input logic eof,
      input int stall, output int waited);
      logic [103:0] exp;
      exp = mk_cmd(tag, pa, btt, eof);
      waited = 0;
      while (!cmd_valid_o && waited < 20) begin
         @(posedge clk_i);
         #1;
         waited++;
      end
      check({nm, "_valid"}, cmd_valid_o, 1'b1);
      check(nm, cmd_data_o, exp);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk_i);
         #1;
         check({nm, "_stall"}, {cmd_valid_o, cmd_data_o}, {1'b1, exp});
      end
      cmd_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      cmd_ready_i = 1'b0;
   endtask

   task automatic expect_quiet(input string nm, input int n);
      logic seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         seen |= cmd_valid_o;
         @(posedge clk_i);
         #1;
      end
      check(nm, seen, 1'b0);
   endtask

   initial begin
      // single-packet first message
      do_reset();
      base = lookups;
      resp_paddr_i = 64'h8000_0000;
      send_req(64'h1000, 28'd256, 16'd3, 1'b1);
      expect_cmd("t1_cmd", 4'd0, 64'h8000_0000, 23'd256, 1'b1, 0, w);
      check("t1_latency", w, 2);
      check("t1_lookup", {lookups - base, lk_vaddr, lk_qpn},
            {32'd1, 64'h1000, 16'd3});
      resp_paddr_i = 64'h5000;
      send_req(64'h3000, 28'd16, 16'd3, 1'b1);
      expect_cmd("t1_again", 4'd1, 64'h5000, 23'd16, 1'b1, 0, w);
      check("t1_relookup", lookups - base, 2);

      // three-packet message on qpn 5
      do_reset();
      base = lookups;
      resp_paddr_i = 64'h2000;
      send_req(64'h7000, 28'd1024, 16'd5, 1'b0);
      expect_cmd("t2_p1", 4'd0, 64'h2000, 23'd1024, 1'b0, 0, w);
      send_req(64'hDEAD, 28'd1024, 16'd5, 1'b0);
      expect_cmd("t2_p2", 4'd1, 64'h2400, 23'd1024, 1'b0, 0, w);
      check("t2_cont_latency", w, 0);
      send_req(64'hBEEF, 28'd1024, 16'd5, 1'b1);
      expect_cmd("t2_p3", 4'd2, 64'h2800, 23'd1024, 1'b1, 0, w);
      check("t2_lookups", lookups - base, 1);

      // split into chunks with back-pressure
      do_reset();
      resp_paddr_i = 64'h1_0000;
      send_req(64'h0, 28'd10000, 16'd7, 1'b1);
      expect_cmd("t3_c1", 4'd0, 64'h1_0000, 23'd4096, 1'b0, 0, w);
      expect_cmd("t3_c2", 4'd1, 64'h1_1000, 23'd4096, 1'b0, 5, w);
      expect_cmd("t3_c3", 4'd2, 64'h1_2000, 23'd1808, 1'b1, 0, w);
      expect_quiet("t3_no_extra", 6);

      // interleaving, alias error, zero-length continuation
      do_reset();
      base = lookups;
      resp_paddr_i = 64'h4000;
      send_req(64'h100, 28'd256, 16'd1, 1'b0);
      expect_cmd("t4_q1a", 4'd0, 64'h4000, 23'd256, 1'b0, 0, w);
      resp_paddr_i = 64'h9000;
      send_req(64'h200, 28'd128, 16'd2, 1'b0);
      expect_cmd("t4_q2a", 4'd1, 64'h9000, 23'd128, 1'b0, 0, w);
      send_req(64'h0, 28'd64, 16'd1, 1'b0);
      expect_cmd("t4_q1b", 4'd2, 64'h4100, 23'd64, 1'b0, 0, w);
      check("t4_lookups", lookups - base, 2);
      send_req(64'h0, 28'd32, 16'd9, 1'b0);
      check("t4_alias_err", {err_o, err_code_o}, {1'b1, 2'b01});
      @(posedge clk_i);
      #1;
      check("t4_err_pulse", {err_o, err_code_o}, {1'b0, 2'b01});
      expect_quiet("t4_alias_nocmd", 5);
      send_req(64'h0, 28'd64, 16'd1, 1'b1);
      expect_cmd("t4_q1c", 4'd3, 64'h4140, 23'd64, 1'b1, 0, w);
      send_req(64'h0, 28'd0, 16'd2, 1'b1);
      expect_quiet("t4_zero_len", 5);
      resp_paddr_i = 64'hA000;
      send_req(64'h300, 28'd16, 16'd2, 1'b1);
      expect_cmd("t4_q2new", 4'd4, 64'hA000, 23'd16, 1'b1, 0, w);
      check("t4_lookups2", lookups - base, 3);

      // reset while a command is stalled
      do_reset();
      resp_paddr_i = 64'h7000;
      send_req(64'h0, 28'd512, 16'd6, 1'b0);
      w = 0;
      while (!cmd_valid_o && w < 20) begin
         @(posedge clk_i);
         #1;
         w++;
      end
      check("t5_pending", cmd_valid_o, 1'b1);
      #2 rst_i = 1'b1;
      #1;
      check("t5_async", {cmd_valid_o, s_rdma_req_ready_o}, 2'b00);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      base = lookups;
      resp_paddr_i = 64'hC000;
      send_req(64'h0, 28'd128, 16'd6, 1'b1);
      expect_cmd("t5_after", 4'd0, 64'hC000, 23'd128, 1'b1, 0, w);
      check("t5_lookup", lookups - base, 1);

`ifdef ROCE_REQ_BOUNDS_CHECK_EN
      // bounds violation on a first packet
      do_reset();
      base = lookups;
      resp_paddr_i  = 64'hB000;
      resp_buflen_i = 48'd512;
      send_req(64'h0, 28'd600, 16'd4, 1'b1);
      w = 0;
      while (!err_o && w < 10) begin
         @(posedge clk_i);
         #1;
         w++;
      end
      check("t6_bounds_err", {err_o, err_code_o}, {1'b1, 2'b10});
      expect_quiet("t6_nocmd", 5);
      resp_buflen_i = 48'hFFFF_FFFF;
      send_req(64'h0, 28'd100, 16'd4, 1'b1);
      expect_cmd("t6_retry", 4'd0, 64'hB000, 23'd100, 1'b1, 0, w);
      check("t6_lookups", lookups - base, 2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
